// File: rtl/ars_pkg.sv
// Shared constants for the SMS4 round tau stage: word width and the S-box table.
package ars_pkg;

  localparam int BWIDTH_DEF = 32;

  typedef logic [7:0] byte_t;

  // SMS4 S-box, indexed by the input byte value
  localparam byte_t SBOX_TABLE [256] = '{
    8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
    8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
    8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
    8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
    8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
    8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
    8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
    8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
    8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
    8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
    8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
    8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
    8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
    8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
    8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
    8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
  };

endpackage

// File: rtl/ars_sbox.sv
// One byte of the SMS4 nonlinear substitution; pure table lookup.
module ars_sbox
  import ars_pkg::*;
(
  input  logic [7:0] din,
  output logic [7:0] dout
);

  assign dout = SBOX_TABLE[din];

endmodule

// File: rtl/ars_tau_stage.sv
// SMS4 round front end: A = X1^X2^X3^rk (stage S1), B = tau(A) (stage S2),
// as a two-deep valid/ready pipeline that streams one word per cycle.
module ars_tau_stage
  import ars_pkg::*;
#(
  parameter int BWIDTH = BWIDTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [0:BWIDTH-1] x1_in,
  input  logic [0:BWIDTH-1] x2_in,
  input  logic [0:BWIDTH-1] x3_in,
  input  logic [0:BWIDTH-1] rk_in,
  output logic              b_valid,
  input  logic              b_ready,
  output logic [0:BWIDTH-1] b_out,
  output logic              busy
);

  localparam int NBYTES = BWIDTH / 8;

  logic [0:BWIDTH-1] s1_a;
  logic              s1_v;
  logic [0:BWIDTH-1] a_next;
  logic [0:BWIDTH-1] b_next;
  logic              s2_adv;
  logic              s1_adv;

  assign a_next = x1_in ^ x2_in ^ x3_in ^ rk_in;

  // Byte 0 is the leftmost (most significant) byte of the word
  for (genvar gi = 0; gi < NBYTES; gi++) begin : g_sbox
    ars_sbox u_sbox (
      .din  (s1_a[8*gi +: 8]),
      .dout (b_next[8*gi +: 8])
    );
  end

  // Handshake: S2 moves when empty or drained; S1 moves when empty or S2 moves.
  // in_ready depends only on state and b_ready, never on in_valid.
  assign s2_adv   = !b_valid || b_ready;
  assign s1_adv   = !s1_v || s2_adv;
  assign in_ready = s1_adv && !rst;
  assign busy     = s1_v || b_valid;

  // Pipeline registers; data only captured when a valid word moves in
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v    <= 1'b0;
      s1_a    <= '0;
      b_valid <= 1'b0;
      b_out   <= '0;
    end else begin
      if (s2_adv) begin
        b_valid <= s1_v;
        if (s1_v) b_out <= b_next;
      end
      if (s1_adv) begin
        s1_v <= in_valid;
        if (in_valid) s1_a <= a_next;
      end
    end
  end

endmodule

// File: tb/tb_ars_tau_stage.sv
// Directed + random bench for ars_tau_stage with a scoreboard queue of
// expected tau results, pushed on input transfer and popped on output transfer.
module tb_ars_tau_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [0:31] x1_in = '0, x2_in = '0, x3_in = '0, rk_in = '0;
  logic        b_valid;
  logic        b_ready = 1'b0;
  logic [0:31] b_out;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int n_out  = 0;
  logic [31:0] exp_q [$];

  // Independent copy of the SMS4 S-box, row by row
  localparam logic [0:2047] TB_SBOX = {
    128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948};

  function automatic logic [7:0] sb(input logic [7:0] v);
    return TB_SBOX[int'(v)*8 +: 8];
  endfunction

  function automatic logic [31:0] tau_ref(input logic [31:0] a);
    return {sb(a[31:24]), sb(a[23:16]), sb(a[15:8]), sb(a[7:0])};
  endfunction

  ars_tau_stage #(.BWIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .x1_in(x1_in), .x2_in(x2_in), .x3_in(x3_in), .rk_in(rk_in),
    .b_valid(b_valid), .b_ready(b_ready), .b_out(b_out), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Scoreboard monitor: inputs are stable mid-cycle, so negedge sees what the next posedge transfers
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (b_valid && b_ready) begin
        n_out++;
        if (exp_q.size() == 0) check("unexpected_output", b_out, 32'hxxxxxxxx);
        else check("sb_output", b_out, exp_q.pop_front());
      end
      if (in_valid && in_ready) exp_q.push_back(tau_ref(x1_in ^ x2_in ^ x3_in ^ rk_in));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 100) begin tick(); n++; end
    check({tag, "_drain_timeout"}, 32'(busy), 32'd0);
  endtask

  task automatic set_word(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] c, input logic [31:0] k);
    x1_in = a; x2_in = b; x3_in = c; rk_in = k;
  endtask

  initial begin
    int acc, first, last, cnt, sent, cyc, out0;
    logic [31:0] held;

    // Reset state
    repeat (3) tick();
    check("rst_b_valid", 32'(b_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_b_out", b_out, 0);

    // Known answer with rk = 00010203, latency two cycles
    rst = 1'b0; b_ready = 1'b1; in_valid = 1'b1;
    set_word(0, 0, 0, 32'h00010203);
    #1 check("kat1_in_ready", 32'(in_ready), 1);
    tick(); in_valid = 1'b0;
    check("kat1_lat1_b_valid", 32'(b_valid), 0);
    check("kat1_busy", 32'(busy), 1);
    tick();
    check("kat1_lat2_b_valid", 32'(b_valid), 1);
    check("kat1_b_out", b_out, 32'hD690E9FE);
    wait_idle("kat1");

    // Known answer A = FF101000
    in_valid = 1'b1; set_word(32'hFF101000, 0, 0, 0);
    tick(); in_valid = 1'b0;
    tick();
    check("kat2_b_valid", 32'(b_valid), 1);
    check("kat2_b_out", b_out, 32'h482B2BD6);
    wait_idle("kat2");

    // Eight back-to-back words at full rate
    first = -1; last = -1; cnt = 0;
    for (int c = 0; c < 12; c++) begin
      in_valid = (c < 8);
      if (c < 8) set_word($urandom, $urandom, $urandom, $urandom);
      #1;
      if (c < 8) check("b2b_in_ready", 32'(in_ready), 1);
      if (b_valid) begin
        cnt++;
        if (first < 0) first = c;
        last = c;
      end
      tick();
    end
    check("b2b_valid_count", cnt, 8);
    check("b2b_valid_contiguous", last - first, 7);
    wait_idle("b2b");

    // Backpressure: only two words fit, output held stable
    b_ready = 1'b0; in_valid = 1'b1; acc = 0;
    set_word(32'h11111111, 32'h02000000, 0, 32'h0);
    for (int c = 0; c < 5; c++) begin
      #1;
      if (in_ready) acc++;
      tick();
      if (acc > 0) set_word(32'h11111111 * (acc + 1), 32'h02000000, 0, 32'h0);
    end
    check("bp_accepted", acc, 2);
    check("bp_in_ready", 32'(in_ready), 0);
    check("bp_b_valid", 32'(b_valid), 1);
    held = b_out;
    check("bp_b_out_first", held, tau_ref(32'h11111111 ^ 32'h02000000));
    repeat (3) begin
      tick();
      check("bp_b_out_stable", b_out, held);
      check("bp_b_valid_stable", 32'(b_valid), 1);
    end
    in_valid = 1'b0; b_ready = 1'b1;
    wait_idle("bp");

    // Reset with both stages full
    b_ready = 1'b0; in_valid = 1'b1;
    set_word(32'hDEADBEEF, 0, 0, 0); tick();
    set_word(32'hCAFEF00D, 0, 0, 0); tick();
    in_valid = 1'b0;
    check("full_in_ready", 32'(in_ready), 0);
    rst = 1'b1; in_valid = 1'b1; set_word(32'h12345678, 0, 0, 0);
    #1 check("rst_mid_in_ready", 32'(in_ready), 0);
    tick();
    rst = 1'b0; in_valid = 1'b0;
    check("rst_mid_b_valid", 32'(b_valid), 0);
    check("rst_mid_busy", 32'(busy), 0);
    b_ready = 1'b1; in_valid = 1'b1; set_word(32'h0BADF00D, 0, 0, 32'h01020304);
    tick(); in_valid = 1'b0;
    tick();
    check("post_rst_b_out", b_out, tau_ref(32'h0BADF00D ^ 32'h01020304));
    wait_idle("post_rst");

    // Random valid/ready toggling, 1000 words
    sent = 0; cyc = 0; out0 = n_out;
    while (sent < 1000 && cyc < 20000) begin
      in_valid = ($urandom_range(0, 2) != 0);
      b_ready  = ($urandom_range(0, 3) != 0);
      set_word($urandom, $urandom, $urandom, $urandom);
      #1;
      if (in_valid && in_ready) sent++;
      tick();
      cyc++;
    end
    in_valid = 1'b0; b_ready = 1'b1;
    wait_idle("rand");
    tick();
    check("rand_sent", sent, 1000);
    check("rand_received", n_out - out0, 1000);
    check("rand_queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
